fft_out_serializer: RTL and testbench
=====================================

FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 Parameter TOTAL_SIZE, 512, samples per frame (power of two).
REQ-002 Parameter WIDTH_IN, 12, signed sample width of the parallel frame.
REQ-003 Parameter WIDTH_IDX, 5, CBFP index width per sample.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 valid_in  input  1  one-cycle pulse: the parallel frame on din_*/idx_* is valid this cycle.
REQ-007 din_i, din_q  input  WIDTH_IN x TOTAL_SIZE (unpacked [0:TOTAL_SIZE-1])  signed real/imag samples.
REQ-008 idx_re, idx_im  input  WIDTH_IDX x TOTAL_SIZE  per-sample CBFP block-exponent indices.
REQ-009 dout_re, dout_im  output  WIDTH_IN  serial sample.
REQ-010 dout_idx_re, dout_idx_im  output  WIDTH_IDX  index paired with the current serial sample.
REQ-011 dout_valid  output  1;  dout_ready  input  1;  dout_last  output  1  (final sample of frame).
REQ-012 busy  output  1  high while a frame is held or streaming.
REQ-013 overrun  output  1  sticky: a frame was dropped;  overrun_clr  input  1  clears it.

Function
REQ-014 States: IDLE, STREAM; IDLE->STREAM on valid_in; STREAM->IDLE on the handshake of sample TOTAL_SIZE-1 unless REQ-020 applies.
REQ-015 In IDLE, valid_in captures all 4*TOTAL_SIZE fields into an internal frame buffer on that edge; the read counter is set to 0.
REQ-016 Latency: valid_in at cycle T gives dout_valid=1 with sample 0 at cycle T+1.
REQ-017 Handshake: a transfer occurs when dout_valid && dout_ready; the counter advances by 1 per transfer; dout_* is held stable while dout_valid && !dout_ready.
REQ-018 Read address = counter, or its log2(TOTAL_SIZE)-bit reversal per REQ-027; dout_idx_* come from the same address as dout_re/dout_im.
REQ-019 dout_last = 1 exactly when dout_valid and the counter is TOTAL_SIZE-1.
REQ-020 valid_in in the same cycle as the final transfer is accepted back-to-back: the new frame is captured, the counter returns to 0, the FSM stays in STREAM, and dout_valid does not deassert.
REQ-021 valid_in in STREAM in any other cycle is ignored: the buffer is unchanged and overrun is set on the next edge.
REQ-022 overrun_clr has priority over a simultaneous set; overrun is otherwise sticky.
REQ-023 busy = (state == STREAM); dout_valid = busy.
REQ-024 No arithmetic is performed on the data; widths pass through unchanged.

Reset
REQ-025 rstn low asynchronously forces IDLE, counter=0, dout_valid=0, dout_last=0, busy=0, overrun=0, and dout_re/dout_im/dout_idx_*=0.
REQ-026 Reset mid-stream abandons the frame; the first valid_in after release starts a new frame at sample 0; buffer contents need not be cleared.

Configuration
REQ-027 With macro FFT_SER_BITREV_EN defined, read order is bit-reversed (sample n from buffer[bitrev(n)]); without it, read order is natural (buffer[n]).

Verification
REQ-028 Ramp frame din_i[k]=k, din_q[k]=-k, idx_re[k]=k%32, macro off, dout_ready=1 -> 512 beats, beat n dout_re=n, dout_im=-n, dout_idx_re=n%32; dout_last only on beat 511; then busy=0.
REQ-029 Same frame with FFT_SER_BITREV_EN -> beat 1 dout_re=256, beat 2 dout_re=128, beat 511 dout_re=511.
REQ-030 dout_ready toggled randomly at 50% -> outputs stable while stalled; all 512 samples in order with no duplicates or drops.
REQ-031 Second valid_in on the beat-511 transfer cycle -> next cycle dout_valid=1 with sample 0 of the new frame; overrun stays 0.
REQ-032 valid_in at beat 100 -> stream continues with the original data; overrun=1 until overrun_clr; overrun_clr and an overrun event in the same cycle -> overrun=0.
REQ-033 rstn asserted at beat 300 -> all outputs 0 immediately; new frame after release streams from sample 0.

Source files
------------

// File: rtl/fft_out_serializer.sv
// fft_out_serializer: captures one parallel FFT frame (real/imag samples plus
// per-sample CBFP indices) and streams it out one sample per valid/ready
// handshake. A new frame may land on the final transfer of the current one
// without a bubble; any other frame arriving mid-stream is dropped and flagged.
// Build macro FFT_SER_BITREV_EN: when defined, the frame is read in
// bit-reversed order (sample n from buffer[bitrev(n)]); otherwise natural order.
module fft_out_serializer #(
   parameter int TOTAL_SIZE = 512,
   parameter int WIDTH_IN   = 12,
   parameter int WIDTH_IDX  = 5
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        valid_in,
   input  logic signed [WIDTH_IN-1:0]  din_i  [0:TOTAL_SIZE-1],
   input  logic signed [WIDTH_IN-1:0]  din_q  [0:TOTAL_SIZE-1],
   input  logic        [WIDTH_IDX-1:0] idx_re [0:TOTAL_SIZE-1],
   input  logic        [WIDTH_IDX-1:0] idx_im [0:TOTAL_SIZE-1],
   output logic signed [WIDTH_IN-1:0]  dout_re,
   output logic signed [WIDTH_IN-1:0]  dout_im,
   output logic        [WIDTH_IDX-1:0] dout_idx_re,
   output logic        [WIDTH_IDX-1:0] dout_idx_im,
   output logic                        dout_valid,
   input  logic                        dout_ready,
   output logic                        dout_last,
   output logic                        busy,
   output logic                        overrun,
   input  logic                        overrun_clr
);

   localparam int AW = $clog2(TOTAL_SIZE);
   localparam logic [0:0]    IDLE     = 1'b0;
   localparam logic [0:0]    STREAM   = 1'b1;
   localparam logic [AW-1:0] LAST_CNT = AW'(TOTAL_SIZE - 1);

   typedef struct packed {
      logic signed [WIDTH_IN-1:0]  re;
      logic signed [WIDTH_IN-1:0]  im;
      logic        [WIDTH_IDX-1:0] ir;
      logic        [WIDTH_IDX-1:0] ii;
   } smp_t;

   logic [0:0]    state;
   logic [AW-1:0] cnt;
   logic [AW-1:0] rd_addr;
   smp_t          frame_buf [0:TOTAL_SIZE-1];
   smp_t          rd;
   logic          xfer, at_last, capture, drop;

   assign busy       = (state == STREAM);
   assign dout_valid = busy;
   assign xfer       = dout_valid & dout_ready;
   assign at_last    = (cnt == LAST_CNT);
   // accept in IDLE, or back-to-back on the final transfer; drop otherwise
   assign capture    = valid_in & (~busy | (xfer & at_last));
   assign drop       = valid_in & busy & ~(xfer & at_last);

`ifdef FFT_SER_BITREV_EN
   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
      logic [AW-1:0] r;
      r = '0;
      for (int b = 0; b < AW; b++) r[b] = v[AW-1-b];
      return r;
   endfunction
   assign rd_addr = bitrev(cnt);
`else
   assign rd_addr = cnt;
`endif

   // frame buffer: whole frame written in one edge; contents survive reset
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int k = 0; k < TOTAL_SIZE; k++)
            frame_buf[k] <= '{re: din_i[k], im: din_q[k], ir: idx_re[k], ii: idx_im[k]};
      end
   end

   // FSM and read counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_in) begin
                  state <= STREAM;
                  cnt   <= '0;
               end
            end
            default: begin
               if (xfer) begin
                  if (at_last) begin
                     cnt <= '0;
                     if (!valid_in) state <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // sticky drop flag; clear wins over a same-cycle drop
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)            overrun <= 1'b0;
      else if (overrun_clr) overrun <= 1'b0;
      else if (drop)        overrun <= 1'b1;
   end

   // outputs are forced to zero whenever nothing is streaming (incl. reset)
   assign rd          = frame_buf[rd_addr];
   assign dout_re     = busy ? rd.re : '0;
   assign dout_im     = busy ? rd.im : '0;
   assign dout_idx_re = busy ? rd.ir : '0;
   assign dout_idx_im = busy ? rd.ii : '0;
   assign dout_last   = busy & at_last;

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer: scoreboard bench. Each accepted frame pushes its
// expected serial sequence into a queue; a monitor compares every presented
// sample against the queue head and pops on handshake.
module tb_fft_out_serializer;

   localparam int N  = 512;
   localparam int WI = 12;
   localparam int WX = 5;
   localparam int LG = $clog2(N);

   typedef struct {
      logic signed [WI-1:0] re;
      logic signed [WI-1:0] im;
      logic [WX-1:0]        ir;
      logic [WX-1:0]        ii;
      logic                 last;
   } exp_t;

   logic clk = 1'b0;
   logic rstn, valid_in, dout_ready, overrun_clr;
   logic signed [WI-1:0] din_i  [0:N-1];
   logic signed [WI-1:0] din_q  [0:N-1];
   logic [WX-1:0]        idx_re [0:N-1];
   logic [WX-1:0]        idx_im [0:N-1];
   logic signed [WI-1:0] dout_re, dout_im;
   logic [WX-1:0]        dout_idx_re, dout_idx_im;
   logic dout_valid, dout_last, busy, overrun;

   exp_t sb[$];
   int total = 0;
   int bad   = 0;

   fft_out_serializer #(.TOTAL_SIZE(N), .WIDTH_IN(WI), .WIDTH_IDX(WX)) dut (
      .clk(clk), .rstn(rstn), .valid_in(valid_in),
      .din_i(din_i), .din_q(din_q), .idx_re(idx_re), .idx_im(idx_im),
      .dout_re(dout_re), .dout_im(dout_im),
      .dout_idx_re(dout_idx_re), .dout_idx_im(dout_idx_im),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
      .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // serial position n reads frame element rev(n) when bit reversal is built in
   function automatic int src_of(input int n);
`ifdef FFT_SER_BITREV_EN
      int r = 0;
      for (int b = 0; b < LG; b++) r = r * 2 + ((n >> b) % 2);
      return r;
`else
      return n;
`endif
   endfunction

   // drive point: one time unit after the falling edge
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic gen_frame(input bit ramp);
      for (int k = 0; k < N; k++) begin
         if (ramp) begin
            din_i[k]  = WI'(k);
            din_q[k]  = WI'(-k);
            idx_re[k] = WX'(k % 32);
            idx_im[k] = WX'(31 - k % 32);
         end else begin
            din_i[k]  = WI'($urandom);
            din_q[k]  = WI'($urandom);
            idx_re[k] = WX'($urandom);
            idx_im[k] = WX'($urandom);
         end
      end
   endtask

   task automatic push_frame();
      exp_t e;
      for (int n = 0; n < N; n++) begin
         e.re   = din_i[src_of(n)];
         e.im   = din_q[src_of(n)];
         e.ir   = idx_re[src_of(n)];
         e.ii   = idx_im[src_of(n)];
         e.last = (n == N - 1);
         sb.push_back(e);
      end
   endtask

   // issue a frame at the current drive point (expected to be accepted)
   task automatic send(input bit ramp, input bit rdy);
      gen_frame(ramp);
      valid_in   = 1'b1;
      dout_ready = rdy;
      push_frame();
   endtask

   // run until the scoreboard holds stop_at entries; returns at a drive point
   task automatic drain(input bit rnd, input int stop_at);
      for (int cyc = 0; cyc < 6000; cyc++) begin
         tick();
         if (sb.size() <= stop_at) return;
         valid_in    = 1'b0;
         overrun_clr = 1'b0;
         dout_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d entries left want %0d", sb.size(), stop_at);
      sb.delete();
   endtask

   // monitor: every presented sample must match the queue head, stalled or not
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = sb[0];
               chk("dout_re",     dout_re,     e.re);
               chk("dout_im",     dout_im,     e.im);
               chk("dout_idx_re", dout_idx_re, e.ir);
               chk("dout_idx_im", dout_idx_im, e.ii);
               chk("dout_last",   dout_last,   e.last);
               if (dout_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      rstn = 1'b0; valid_in = 1'b0; dout_ready = 1'b0; overrun_clr = 1'b0;
      gen_frame(1'b0);
      #2;
      chk("rst_valid", dout_valid, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_last",  dout_last, 0);
      chk("rst_ovr",   overrun, 0);
      chk("rst_re",    dout_re, 0);
      tick(); tick();
      rstn = 1'b1;
      tick();

      // ramp frame, always ready
      send(1'b1, 1'b1);
      tick();
      chk("latency_valid", dout_valid, 1);
      valid_in = 1'b0;
      drain(1'b0, 0);
      chk("ramp_end_busy",  busy, 0);
      chk("ramp_end_valid", dout_valid, 0);

      // random frame, random back-pressure
      send(1'b0, 1'b1);
      drain(1'b1, 0);
      chk("rnd_end_busy", busy, 0);

      // back-to-back frame on the final transfer
      send(1'b0, 1'b1);
      drain(1'b1, 1);
      send(1'b0, 1'b1);
      tick();
      chk("b2b_valid", dout_valid, 1);
      chk("b2b_ovr",   overrun, 0);
      valid_in = 1'b0;
      drain(1'b1, 0);
      chk("b2b_ovr_end", overrun, 0);
      chk("b2b_end_busy", busy, 0);

      // mid-stream frame at beat 100 is dropped and flagged
      send(1'b1, 1'b1);
      drain(1'b0, N - 100);
      gen_frame(1'b0);
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      chk("ovr_set", overrun, 1);
      tick(); tick();
      chk("ovr_sticky", overrun, 1);
      valid_in    = 1'b1;
      overrun_clr = 1'b1;
      tick();
      chk("ovr_clr_wins", overrun, 0);
      valid_in    = 1'b0;
      overrun_clr = 1'b0;
      drain(1'b0, 0);
      chk("ovr_after", overrun, 0);

      // reset at beat 300 abandons the frame
      send(1'b0, 1'b1);
      drain(1'b1, N - 300);
      rstn = 1'b0;
      #1;
      chk("mrst_valid", dout_valid, 0);
      chk("mrst_last",  dout_last, 0);
      chk("mrst_busy",  busy, 0);
      chk("mrst_re",    dout_re, 0);
      chk("mrst_im",    dout_im, 0);
      chk("mrst_ir",    dout_idx_re, 0);
      chk("mrst_ii",    dout_idx_im, 0);
      sb.delete();
      tick();
      rstn = 1'b1;
      tick();
      send(1'b1, 1'b1);
      tick();
      chk("post_rst_valid", dout_valid, 1);
      valid_in = 1'b0;
      drain(1'b1, 0);
      chk("post_rst_busy", busy, 0);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
